// File: rtl/ysyx_220066_pkg.sv
// Shared encodings for the ysyx_220066 load/store unit.
package ysyx_220066_pkg;

    localparam logic [2:0] MOP_B  = 3'b000;
    localparam logic [2:0] MOP_H  = 3'b001;
    localparam logic [2:0] MOP_W  = 3'b010;
    localparam logic [2:0] MOP_D  = 3'b011;
    localparam logic [2:0] MOP_BU = 3'b100;
    localparam logic [2:0] MOP_HU = 3'b101;
    localparam logic [2:0] MOP_WU = 3'b110;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/ysyx_220066_lsu_align.sv
// Combinational byte-lane helper: strobes and store lane shift, load
// extraction and extension, and misaligned/illegal op detection.
module ysyx_220066_lsu_align
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int OW   = $clog2(XLEN/8)
) (
    input  logic [2:0]        op,
    input  logic [OW-1:0]     offset,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic              bad,
    output logic [XLEN/8-1:0] strb,
    output logic [XLEN-1:0]   wdata_lane,
    output logic [XLEN-1:0]   rdata_ext
);
    localparam int NB = XLEN/8;

    logic [3:0]      nbytes;
    logic [8:0]      bmask_wide;
    logic [7:0]      bmask;
    logic [XLEN-1:0] dmask;
    logic [XLEN-1:0] shifted;
    logic            illegal;
    logic            misalign;

    // Size decode, lane placement and load extension.
    always_comb begin
        nbytes     = 4'd1 << op[1:0];
        bmask_wide = (9'd1 << nbytes) - 9'd1;
        bmask      = bmask_wide[7:0];
        illegal    = (op == 3'b111) ||
                     ((XLEN == 32) && ((op[1:0] == 2'b11) || (op == MOP_WU)));
        misalign   = (offset & OW'(nbytes - 4'd1)) != '0;
        bad        = illegal || misalign;
        strb       = NB'(bmask) << offset;
        dmask      = '0;
        for (int i = 0; i < NB; i++) begin
            dmask[8*i +: 8] = {8{bmask[i]}};
        end
        wdata_lane = (wdata & dmask) << {offset, 3'b000};
        shifted    = rdata >> {offset, 3'b000};
        case (op)
            MOP_B:   rdata_ext = XLEN'($signed(shifted[7:0]));
            MOP_BU:  rdata_ext = XLEN'(shifted[7:0]);
            MOP_H:   rdata_ext = XLEN'($signed(shifted[15:0]));
            MOP_HU:  rdata_ext = XLEN'(shifted[15:0]);
            MOP_W:   rdata_ext = XLEN'($signed(shifted[31:0]));
            MOP_WU:  rdata_ext = XLEN'(shifted[31:0]);
            default: rdata_ext = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_220066_lsu.sv
// Multi-cycle handshaked load/store unit with bus-timeout watchdog.
//
// state   | meaning
// IDLE    | ready for a request
// BUS     | bus beat outstanding, watchdog counting wait cycles
// RESP    | response presented, waiting for resp_ready
module ysyx_220066_lsu
    import ysyx_220066_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int AW      = 64,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [2:0]        req_op,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [1:0]        resp_err,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_err
);
    localparam int NB = XLEN/8;
    localparam int OW = $clog2(NB);
    localparam int CW = $clog2(TIMEOUT + 1);

    lsu_state_t state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      op_q, op_n;
    logic [OW-1:0]   off_q, off_n;
    logic            wr_q, wr_n;
    logic            resp_valid_n, mem_valid_n, mem_wr_n;
    logic [1:0]      resp_err_n;
    logic [XLEN-1:0] resp_rdata_n, mem_wdata_n;
    logic [AW-1:0]   mem_addr_n;
    logic [NB-1:0]   mem_wstrb_n;

    logic [2:0]      al_op;
    logic [OW-1:0]   al_off;
    logic            al_bad;
    logic [NB-1:0]   al_strb;
    logic [XLEN-1:0] al_wdata, al_rdata;

    assign req_ready = (state == ST_IDLE);

    // Before acceptance the aligner sees the incoming request; afterwards
    // the latched op/offset so load extraction uses the accepted access.
    assign al_op  = (state == ST_IDLE) ? req_op : op_q;
    assign al_off = (state == ST_IDLE) ? req_addr[OW-1:0] : off_q;

    ysyx_220066_lsu_align #(.XLEN(XLEN), .OW(OW)) u_align (
        .op         (al_op),
        .offset     (al_off),
        .wdata      (req_wdata),
        .rdata      (mem_rdata),
        .bad        (al_bad),
        .strb       (al_strb),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        op_n         = op_q;
        off_n        = off_q;
        wr_n         = wr_q;
        resp_valid_n = resp_valid;
        resp_err_n   = resp_err;
        resp_rdata_n = resp_rdata;
        mem_valid_n  = mem_valid;
        mem_wr_n     = mem_wr;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_wstrb_n  = mem_wstrb;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    op_n  = req_op;
                    off_n = req_addr[OW-1:0];
                    wr_n  = req_wr;
                    if (al_bad) begin
                        state_n      = ST_RESP;
                        resp_valid_n = 1'b1;
                        resp_err_n   = ERR_MISALIGN;
                        resp_rdata_n = '0;
                    end else begin
                        state_n     = ST_BUS;
                        mem_valid_n = 1'b1;
                        mem_wr_n    = req_wr;
                        mem_addr_n  = req_addr & ~AW'(NB - 1);
                        mem_wdata_n = req_wr ? al_wdata : '0;
                        mem_wstrb_n = req_wr ? al_strb : '0;
                    end
                end
            end
            ST_BUS: begin
                if (mem_ready) begin
                    state_n      = ST_RESP;
                    mem_valid_n  = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = mem_err ? ERR_BUS : ERR_OK;
                    resp_rdata_n = (mem_err || wr_q) ? '0 : al_rdata;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    state_n      = ST_RESP;
                    mem_valid_n  = 1'b0;
                    resp_valid_n = 1'b1;
                    resp_err_n   = ERR_TIMEOUT;
                    resp_rdata_n = '0;
                    cnt_n        = cnt + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_n      = ST_IDLE;
                    resp_valid_n = 1'b0;
                    cnt_n        = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and registered outputs, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            off_q      <= '0;
            wr_q       <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= ERR_OK;
            resp_rdata <= '0;
            mem_valid  <= 1'b0;
            mem_wr     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            op_q       <= op_n;
            off_q      <= off_n;
            wr_q       <= wr_n;
            resp_valid <= resp_valid_n;
            resp_err   <= resp_err_n;
            resp_rdata <= resp_rdata_n;
            mem_valid  <= mem_valid_n;
            mem_wr     <= mem_wr_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_wstrb  <= mem_wstrb_n;
        end
    end

endmodule

// File: tb/tb_ysyx_220066_lsu.sv
// Self-checking bench for ysyx_220066_lsu (XLEN=64, TIMEOUT=4).
module tb_ysyx_220066_lsu;
    import ysyx_220066_pkg::*;

    localparam int XLEN = 64;
    localparam int AW = 64;
    localparam int TIMEOUT = 4;

    logic            clk, rst;
    logic            req_valid, req_ready, req_wr;
    logic [2:0]      req_op;
    logic [AW-1:0]   req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            resp_valid, resp_ready;
    logic [XLEN-1:0] resp_rdata;
    logic [1:0]      resp_err;
    logic            mem_valid, mem_ready, mem_wr, mem_err;
    logic [AW-1:0]   mem_addr;
    logic [XLEN-1:0] mem_wdata, mem_rdata;
    logic [7:0]      mem_wstrb;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  err;
        logic [63:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    ysyx_220066_lsu #(.XLEN(XLEN), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "global timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one accepting edge; returns in cycle T+1.
    task automatic drive_req(input logic wr, input logic [2:0] op,
                             input logic [63:0] addr, input logic [63:0] wd);
        req_wr = wr; req_op = op; req_addr = addr; req_wdata = wd;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int cyc);
        cyc = 0;
        while (!resp_valid && cyc < 20) begin
            step();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hs got rdy=%b rv=%b mv=%b exp 1 0 0", req_ready, resp_valid, mem_valid);
        end
        checks++;
        if (resp_err !== 2'b00 || resp_rdata !== 64'h0 || mem_wr !== 1'b0 ||
            mem_addr !== 64'h0 || mem_wdata !== 64'h0 || mem_wstrb !== 8'h0) begin
            failures++;
            $display("FAIL reset_regs got err=%b rd=%h wr=%b a=%h wd=%h st=%h exp all 0",
                     resp_err, resp_rdata, mem_wr, mem_addr, mem_wdata, mem_wstrb);
        end
        rst = 1'b1;
        step();
    endtask

    localparam logic [2:0]  LD_OP   [8] = '{MOP_B, MOP_BU, MOP_H, MOP_HU, MOP_W, MOP_WU, MOP_D, MOP_B};
    localparam logic [63:0] LD_ADDR [8] = '{64'h1003, 64'h1003, 64'h1002, 64'h1006,
                                            64'h1004, 64'h1000, 64'h1008, 64'h1010};
    localparam logic [63:0] LD_RD   [8] = '{64'h00000000_80000000, 64'h00000000_80000000,
                                            64'h87654321_FEDCBA98, 64'h87654321_FEDCBA98,
                                            64'h87654321_FEDCBA98, 64'h87654321_FEDCBA98,
                                            64'h87654321_FEDCBA98, 64'h87654321_FEDCBA98};
    localparam logic [63:0] LD_EXP  [8] = '{64'hFFFFFFFF_FFFFFF80, 64'h00000000_00000080,
                                            64'hFFFFFFFF_FFFFFEDC, 64'h00000000_00008765,
                                            64'hFFFFFFFF_87654321, 64'h00000000_FEDCBA98,
                                            64'h87654321_FEDCBA98, 64'hFFFFFFFF_FFFFFF98};

    task automatic test_loads();
        mem_ready = 1'b1; mem_err = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_rdata = LD_RD[i];
            drive_req(1'b0, LD_OP[i], LD_ADDR[i], 64'h0);
            sb.push_back('{ERR_OK, LD_EXP[i]});
            checks++;
            if (mem_valid !== 1'b1 || mem_wr !== 1'b0 || mem_wstrb !== 8'h00 ||
                mem_addr !== (LD_ADDR[i] & ~64'h7)) begin
                failures++;
                $display("FAIL load_bus[%0d] got mv=%b wr=%b st=%h a=%h exp 1 0 00 %h",
                         i, mem_valid, mem_wr, mem_wstrb, mem_addr, LD_ADDR[i] & ~64'h7);
            end
            step();
            e = sb.pop_front();
            checks++;
            if (resp_valid !== 1'b1 || resp_err !== e.err || resp_rdata !== e.data) begin
                failures++;
                $display("FAIL load_resp[%0d] got rv=%b err=%b rd=%h exp 1 %b %h",
                         i, resp_valid, resp_err, resp_rdata, e.err, e.data);
            end
            step();
            checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
                failures++;
                $display("FAIL load_ret[%0d] got rdy=%b rv=%b exp 1 0", i, req_ready, resp_valid);
            end
        end
    endtask

    localparam logic [2:0]  ST_OP   [4] = '{MOP_H, MOP_B, MOP_W, MOP_D};
    localparam logic [63:0] ST_ADDR [4] = '{64'h2006, 64'h2001, 64'h2004, 64'h2000};
    localparam logic [63:0] ST_WD   [4] = '{64'hABCD, 64'h5A, 64'hDEADBEEF, 64'h01234567_89ABCDEF};
    localparam logic [63:0] ST_LANE [4] = '{64'hABCD0000_00000000, 64'h00000000_00005A00,
                                            64'hDEADBEEF_00000000, 64'h01234567_89ABCDEF};
    localparam logic [7:0]  ST_STRB [4] = '{8'hC0, 8'h02, 8'hF0, 8'hFF};

    task automatic test_stores();
        int cyc;
        mem_ready = 1'b1; mem_err = 1'b0; resp_ready = 1'b1;
        mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, ST_OP[i], ST_ADDR[i], ST_WD[i]);
            sb.push_back('{ERR_OK, 64'h0});
            checks++;
            if (mem_valid !== 1'b1 || mem_wr !== 1'b1 || mem_wdata !== ST_LANE[i] ||
                mem_wstrb !== ST_STRB[i] || mem_addr !== 64'h2000) begin
                failures++;
                $display("FAIL store_bus[%0d] got mv=%b wr=%b wd=%h st=%h a=%h exp 1 1 %h %h 2000",
                         i, mem_valid, mem_wr, mem_wdata, mem_wstrb, mem_addr, ST_LANE[i], ST_STRB[i]);
            end
            wait_resp(cyc);
            e = sb.pop_front();
            checks++;
            if (cyc !== 1 || resp_err !== e.err || resp_rdata !== e.data) begin
                failures++;
                $display("FAIL store_resp[%0d] got lat=%0d err=%b rd=%h exp 1 %b %h",
                         i, cyc, resp_err, resp_rdata, e.err, e.data);
            end
            step();
        end
    endtask

    localparam logic [2:0]  MA_OP   [4] = '{MOP_W, 3'b111, MOP_H, MOP_D};
    localparam logic [63:0] MA_ADDR [4] = '{64'h3002, 64'h3000, 64'h3001, 64'h3004};

    task automatic test_misalign();
        mem_ready = 1'b1; mem_err = 1'b0; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b0, MA_OP[i], MA_ADDR[i], 64'h0);
            sb.push_back('{ERR_MISALIGN, 64'h0});
            e = sb.pop_front();
            checks++;
            if (resp_valid !== 1'b1 || mem_valid !== 1'b0 || resp_err !== e.err ||
                resp_rdata !== e.data) begin
                failures++;
                $display("FAIL misalign[%0d] got rv=%b mv=%b err=%b rd=%h exp 1 0 %b %h",
                         i, resp_valid, mem_valid, resp_err, resp_rdata, e.err, e.data);
            end
            step();
            checks++;
            if (mem_valid !== 1'b0 || req_ready !== 1'b1) begin
                failures++;
                $display("FAIL misalign_ret[%0d] got mv=%b rdy=%b exp 0 1", i, mem_valid, req_ready);
            end
        end
    endtask

    task automatic test_timeout();
        int hi;
        int cyc;
        mem_ready = 1'b0; mem_err = 1'b0; resp_ready = 1'b0;
        drive_req(1'b0, MOP_D, 64'h5000, 64'h0);
        sb.push_back('{ERR_TIMEOUT, 64'h0});
        hi = 0;
        while (mem_valid && hi < 20) begin
            hi++;
            step();
        end
        checks++;
        if (hi !== TIMEOUT) begin
            failures++;
            $display("FAIL timeout_len got %0d cycles exp %0d", hi, TIMEOUT);
        end
        e = sb.pop_front();
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== e.err || resp_rdata !== e.data) begin
            failures++;
            $display("FAIL timeout_resp got rv=%b err=%b rd=%h exp 1 %b %h",
                     resp_valid, resp_err, resp_rdata, e.err, e.data);
        end
        req_valid = 1'b1; req_wr = 1'b0; req_op = MOP_B; req_addr = 64'h5001;
        mem_ready = 1'b1; mem_rdata = 64'h0000_0000_0000_7F00;
        step();
        checks++;
        if (req_ready !== 1'b0 || mem_valid !== 1'b0 || resp_valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout_hold got rdy=%b mv=%b rv=%b exp 0 0 1", req_ready, mem_valid, resp_valid);
        end
        resp_ready = 1'b1;
        step();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL timeout_release got rdy=%b rv=%b exp 1 0", req_ready, resp_valid);
        end
        step();
        req_valid = 1'b0;
        sb.push_back('{ERR_OK, 64'h7F});
        checks++;
        if (mem_valid !== 1'b1 || mem_addr !== 64'h5000) begin
            failures++;
            $display("FAIL timeout_next_bus got mv=%b a=%h exp 1 5000", mem_valid, mem_addr);
        end
        wait_resp(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 1 || resp_err !== e.err || resp_rdata !== e.data) begin
            failures++;
            $display("FAIL timeout_next_resp got lat=%0d err=%b rd=%h exp 1 %b %h",
                     cyc, resp_err, resp_rdata, e.err, e.data);
        end
        step();
    endtask

    // The ready arrives on the same edge the watchdog would fire.
    task automatic test_bus_err();
        mem_ready = 1'b0; mem_err = 1'b0; resp_ready = 1'b0;
        mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        drive_req(1'b0, MOP_D, 64'h6000, 64'h0);
        sb.push_back('{ERR_BUS, 64'h0});
        step(); step(); step();
        checks++;
        if (mem_valid !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL buserr_wait got mv=%b rv=%b exp 1 0", mem_valid, resp_valid);
        end
        mem_ready = 1'b1; mem_err = 1'b1;
        step();
        mem_ready = 1'b0; mem_err = 1'b0;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (resp_valid !== 1'b1 || mem_valid !== 1'b0 || resp_err !== e.err ||
                resp_rdata !== e.data) begin
                failures++;
                $display("FAIL buserr_hold[%0d] got rv=%b mv=%b err=%b rd=%h exp 1 0 %b %h",
                         i, resp_valid, mem_valid, resp_err, resp_rdata, e.err, e.data);
            end
            step();
        end
        resp_ready = 1'b1;
        step();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL buserr_release got rv=%b rdy=%b exp 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        mem_ready = 1'b0; mem_err = 1'b0; resp_ready = 1'b1;
        drive_req(1'b0, MOP_D, 64'h7000, 64'h0);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        checks++;
        if (mem_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_addr !== 64'h0) begin
            failures++;
            $display("FAIL reset_mid got mv=%b rv=%b rdy=%b a=%h exp 0 0 1 0",
                     mem_valid, resp_valid, req_ready, mem_addr);
        end
        mem_ready = 1'b1; mem_rdata = 64'h11223344_55667788;
        drive_req(1'b0, MOP_D, 64'h7008, 64'h0);
        sb.push_back('{ERR_OK, 64'h11223344_55667788});
        wait_resp(cyc);
        e = sb.pop_front();
        checks++;
        if (cyc !== 1 || resp_err !== e.err || resp_rdata !== e.data) begin
            failures++;
            $display("FAIL reset_mid_next got lat=%0d err=%b rd=%h exp 1 %b %h",
                     cyc, resp_err, resp_rdata, e.err, e.data);
        end
        step();
    endtask

    initial begin
        req_valid = 1'b0; req_wr = 1'b0; req_op = 3'b000; req_addr = '0; req_wdata = '0;
        resp_ready = 1'b1; mem_ready = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        rst = 1'b0;
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_bus_err();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_lsu.md
# ysyx_220066_lsu

Parametrised load/store unit that replaces the single-cycle combinational memory access of the ysyx_220066 core with a multi-cycle, handshaked access. It sits between the EX stage (which supplies address, store data and MemOp) and a variable-latency memory bus. It handles:
- byte-lane alignment and strobes,
- load sign/zero extension,
- misalignment detection,
- bus errors,
- a bus-timeout watchdog.

## Interface
Parameters:
- XLEN, 64, data/register width; 32 or 64
- AW, 64, address width
- TIMEOUT, 255, max cycles waiting on mem_ready before abort; ≥1

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset; synchronous, active-low (asserted when 0)
- req_valid  in  1  access request
- req_ready  out  1  LSU can accept a request
- req_wr  in  1  1 = store, 0 = load
- req_op  in  3  MemOp (funct3): 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
- req_addr  in  AW  byte address
- req_wdata  in  XLEN  store data, LSB-justified
- resp_valid  out  1  response available
- resp_ready  in  1  consumer takes response
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors
- resp_err  out  2  00 ok, 01 misaligned/illegal op, 10 bus error, 11 timeout
- mem_valid  out  1  bus request
- mem_ready  in  1  bus completes the current beat
- mem_wr  out  1  bus write
- mem_addr  out  AW  req_addr with low log2(XLEN/8) bits cleared
- mem_wdata  out  XLEN  store data shifted to its byte lanes
- mem_wstrb  out  XLEN/8  byte-enable mask; all 0 on reads
- mem_rdata  in  XLEN  full bus word
- mem_err  in  1  error, sampled with mem_ready

## Operation
- States: IDLE, BUS, RESP. Reset state IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_err=00, resp_rdata=0, mem_valid=0, mem_wr=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, timeout counter=0.
- req_ready = (state==IDLE). A request is accepted when req_valid && req_ready. On acceptance, op, offset, wr and wdata are latched.

IDLE → RESP (no bus access):
- Taken when the op is illegal: 111, or any d/wu op when XLEN=32.
- Taken when the access is misaligned: addr not a multiple of the access size.
- resp_err=01.

IDLE → BUS (otherwise):
- mem_valid=1, with mem_addr/mem_wr/mem_wdata/mem_wstrb registered.
- Strobe = size mask << offset. Example: sh at offset 2 gives wstrb 0x0C.

BUS:
- mem_valid and all mem_* outputs stay stable until mem_ready.
- On mem_ready: mem_valid drops, state goes to RESP.
  - If mem_err=1: resp_err=10, rdata=0.
  - Else: resp_err=00. For loads, rdata = mem_rdata >> (8·offset), truncated to size, then sign-extended (b/h/w/d) or zero-extended (bu/hu/wu).
- Counter increments each BUS cycle with mem_ready=0. When it reaches TIMEOUT: mem_valid drops, resp_err=11, state goes to RESP.
- mem_ready and the timeout in the same cycle: mem_ready wins.

RESP:
- resp_valid=1, resp_* held stable until resp_ready.
- On resp_ready: back to IDLE, resp_valid drops, counter clears.
- No new request is accepted in RESP; single outstanding access only.

Reset:
- rst=0 at any edge, mid-BUS or mid-RESP: all state returns to reset values on that edge. mem_valid and resp_valid are 0 the following cycle, and the in-flight access is abandoned without a response.

## Timing
- Accept at edge T: mem_valid=1 in cycle T+1.
- Zero-wait bus (mem_ready=1 in T+1): resp_valid=1 in cycle T+2. Minimum load/store latency is 2 cycles.
- Misaligned/illegal: resp_valid=1 in cycle T+1; mem_valid never rises.
- Each wait cycle adds 1. Timeout fires on the edge ending the TIMEOUT-th waiting cycle; resp_valid rises the next cycle.
- Back-to-back: with resp_ready=1 in the RESP cycle, req_ready=1 in the next cycle. Throughput is at most one access per 3 cycles.
- Every output is registered, except req_ready, which decodes state.

## Structure
- Shared package ysyx_220066_pkg:
  - MemOp encodings (MOP_B … MOP_WU)
  - resp_err codes (ERR_OK, ERR_MISALIGN, ERR_BUS, ERR_TIMEOUT)
  - LSU state enum
- Sub-module ysyx_220066_lsu_align: purely combinational.
  - Store side: size mask, strobe, lane shift.
  - Load side: extract and extend.
  - Misalign/illegal check.
  - It is instantiated once; the FSM, counter and registers stay in ysyx_220066_lsu.

## Test plan
- XLEN=64. Load lb at addr 0x1003 with mem_rdata=0x00000000_80000000: mem_addr=0x1000, wstrb=0. resp_rdata=0xFFFFFFFF_FFFFFF80 at T+2. Repeat as lbu: 0x80.
- Store sh, addr 0x2006, wdata=0xABCD: mem_wdata=0xABCD0000_00000000, wstrb=0xC0, mem_wr=1. resp_err=00, rdata=0.
- Load lw at addr 0x3002: resp_err=01 at T+1, mem_valid stays 0. Op 111 behaves identically.
- TIMEOUT=4, mem_ready held 0: mem_valid high 4 cycles then drops. resp_err=11. The next request is accepted after resp_ready.
- ld with mem_ready=1 and mem_err=1 after 3 wait cycles: resp_err=10, rdata=0. resp_valid is held 5 cycles with resp_ready=0, data stable throughout.
- rst=0 in the second BUS cycle: next cycle mem_valid=0, resp_valid=0, req_ready=1. The next request completes normally.
